alu_sub: RTL and testbench
==========================

# alu_sub

32-bit two's-complement subtractor slice of the ALU, computing Result = In1 − In2 with ARM-style NZCV condition flags. A set-flags control (S) selects whether the flag register output is updated from this operation or carries the incoming flags through unchanged. Outputs are registered, one cycle after the operands are applied. The ALU top-level mux instantiates it as module SUB.

## Interface
- No parameters. Data width is fixed at 32 bits.
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- In1  input  32  minuend, signed two's complement.
- In2  input  32  subtrahend, signed two's complement.
- Flag  input  4  current flags {N,Z,C,V}: bit3=N, bit2=Z, bit1=C, bit0=V.
- S  input  1  set-flags enable.
- Result  output  32  registered In1 − In2, signed.
- New_Flag  output  4  registered updated flags {N,Z,C,V}.
- Port order for positional instantiation: In1, In2, Result, Flag, S, New_Flag, clk, rst.

## Operation
- diff = In1 + ~In2 + 1, computed at 33 bits. carry_out is bit 32. Result is bits 31:0, which wrap modulo 2^32.
- N = diff[31].
- Z = (diff[31:0] == 0).
- C = carry_out, using the ARM convention. C=1 means no borrow, i.e. unsigned In1 ≥ In2. C=0 means a borrow occurred.
- V = (In1[31] != In2[31]) && (diff[31] != In1[31]). This is signed overflow.
- S=1: New_Flag <= {N,Z,C,V}.
- S=0: New_Flag <= Flag, passed through unchanged. Result is still updated.
- The flags always describe the true wrapped difference, regardless of any Result post-processing (see Configuration).
- X or Z values on the inputs are not required to produce defined outputs.

## Timing
- Latency is 1 cycle. Inputs sampled at rising edge k appear on Result and New_Flag after edge k.
- Throughput is one operation per cycle. There is no handshake and no stall.
- Reset: when rst=1 at a rising edge, Result <= 32'h0 and New_Flag <= 4'b0000. Reset has priority over S and over all data inputs.
- Reset asserted mid-stream discards the operation sampled on that edge. The first valid result appears one cycle after the first edge with rst=0.
- Outputs hold their values between edges. There is no combinational path from any input to any output.

## Configuration
- Macro: ALU_SUB_SAT_EN.
- When defined, saturating mode is enabled:
  - On V=1, Result is clamped to 32'h7FFF_FFFF if In1 is non-negative, or to 32'h8000_0000 if In1 is negative.
  - Otherwise Result is the wrapped difference.
  - Flags are still computed from the unsaturated difference, so V=1 reports that saturation occurred.
- When not defined: Result is always the wrapped 32-bit difference. There is no saturation logic.

## Test plan
- rst=1 for 2 cycles with arbitrary inputs -> Result=0, New_Flag=0000. With rst=1 and S=1 -> outputs still 0.
- Flag=0000, S=1. One cycle after each vector is applied, check:
  - In1=2, In2=3 -> Result=−1, New_Flag=1000.
  - In1=1, In2=−3 -> Result=4, New_Flag=0000.
  - In1=−6, In2=−2 -> Result=−4, New_Flag=1000.
- Flag=0000, S=1:
  - In1=32'hFFFF_FFFF, In2=9 -> Result=−10, New_Flag=1010.
  - In1=10, In2=10 -> Result=0, New_Flag=0110.
  - In1=4, In2=−4 -> Result=8, New_Flag=0000.
- Overflow, S=1: In1=32'h8000_0000, In2=1 -> New_Flag=0011. Result=32'h7FFF_FFFF in wrap mode; 32'h8000_0000 with ALU_SUB_SAT_EN defined.
  - Also in1=32'h7FFF_FFFF, In2=−1 -> New_Flag=1001. Result=32'h8000_0000 wrapped; 32'h7FFF_FFFF when saturated.
- Flag pass-through: Flag=0101, S=0, In1=10, In2=10 -> Result=0, New_Flag=0101. Then raise S to 1 with the same operands -> New_Flag=0110 one cycle later.

Source files
------------

// File: rtl/alu_sub.sv
// rtl/alu_sub.sv - 32-bit registered subtractor with NZCV flags
// Optional saturating Result when ALU_SUB_SAT_EN is defined.
module alu_sub (
    input  logic [31:0] In1,
    input  logic [31:0] In2,
    output logic [31:0] Result,
    input  logic [3:0]  Flag,
    input  logic        S,
    output logic [3:0]  New_Flag,
    input  logic        clk,
    input  logic        rst
);

    logic [32:0] diff;
    logic        n_flag;
    logic        z_flag;
    logic        c_flag;
    logic        v_flag;
    logic [31:0] result_d;
    logic [31:0] result_q;
    logic [3:0]  flag_d;
    logic [3:0]  flag_q;

    // Carry out of In1 + ~In2 + 1 is the ARM "no borrow" carry.
    assign diff   = {1'b0, In1} + {1'b0, ~In2} + 33'd1;
    assign n_flag = diff[31];
    assign z_flag = (diff[31:0] == 32'd0);
    assign c_flag = diff[32];
    assign v_flag = (In1[31] != In2[31]) && (diff[31] != In1[31]);

    always_comb begin
        result_d = diff[31:0];
`ifdef ALU_SUB_SAT_EN
        if (v_flag) begin
            result_d = In1[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end
`endif
        flag_d = S ? {n_flag, z_flag, c_flag, v_flag} : Flag;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= 32'h0;
            flag_q   <= 4'b0000;
        end else begin
            result_q <= result_d;
            flag_q   <= flag_d;
        end
    end

    assign Result   = result_q;
    assign New_Flag = flag_q;

endmodule

// File: tb/tb_alu_sub.sv
// tb/tb_alu_sub.sv - scoreboard bench for alu_sub
module tb_alu_sub;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in1;
    logic [31:0] in2;
    logic [3:0]  flag;
    logic        s;
    logic [31:0] result;
    logic [3:0]  new_flag;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        string       tag;
        logic [31:0] res;
        logic [3:0]  fl;
    } exp_t;

    exp_t sb[$];

`ifdef ALU_SUB_SAT_EN
    localparam logic [31:0] OVF_NEG_RES = 32'h8000_0000;
    localparam logic [31:0] OVF_POS_RES = 32'h7FFF_FFFF;
`else
    localparam logic [31:0] OVF_NEG_RES = 32'h7FFF_FFFF;
    localparam logic [31:0] OVF_POS_RES = 32'h8000_0000;
`endif

    always #5 clk = ~clk;

    alu_sub dut (
        .In1      (in1),
        .In2      (in2),
        .Result   (result),
        .Flag     (flag),
        .S        (s),
        .New_Flag (new_flag),
        .clk      (clk),
        .rst      (rst)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Independent reference: unsigned compare for C, 64-bit signed range for V.
    function automatic exp_t model(input string tag, input logic [31:0] a, input logic [31:0] b,
                                   input logic [3:0] f, input logic sv);
        exp_t        e;
        logic [31:0] d;
        longint      sa;
        longint      sb_l;
        longint      sd;
        logic        v;
        sa   = longint'($signed(a));
        sb_l = longint'($signed(b));
        sd   = sa - sb_l;
        d    = a - b;
        v    = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
        e.tag = tag;
        e.res = d;
`ifdef ALU_SUB_SAT_EN
        if (v) e.res = (sd > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
`endif
        e.fl = sv ? {d[31], (d == 32'd0), (a >= b), v} : f;
        return e;
    endfunction

    task automatic drive(input string tag, input logic r, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] f, input logic sv,
                         input logic [31:0] er, input logic [3:0] ef);
        exp_t e;
        rst  = r;
        in1  = a;
        in2  = b;
        flag = f;
        s    = sv;
        e.tag = tag;
        e.res = er;
        e.fl  = ef;
        sb.push_back(e);
    endtask

    task automatic drive_model(input string tag, input logic [31:0] a, input logic [31:0] b,
                               input logic [3:0] f, input logic sv);
        exp_t e;
        e = model(tag, a, b, f, sv);
        drive(tag, 1'b0, a, b, f, sv, e.res, e.fl);
    endtask

    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL scoreboard_empty: got 0 entries expected 1");
        end else begin
            e = sb.pop_front();
            check_val({e.tag, "_res"}, result, e.res);
            check_val({e.tag, "_flg"}, {28'd0, new_flag}, {28'd0, e.fl});
        end
    endtask

    initial begin
        drive("rst0", 1'b1, 32'h1234_5678, 32'h0000_0001, 4'b1111, 1'b0, 32'h0, 4'b0000);
        step();
        drive("rst1", 1'b1, 32'hDEAD_BEEF, 32'h0BAD_F00D, 4'b1010, 1'b1, 32'h0, 4'b0000);
        step();

        drive("v2m3",    1'b0, 32'd2, 32'd3, 4'b0000, 1'b1, 32'hFFFF_FFFF, 4'b1000);
        step();
        drive("v1mn3",   1'b0, 32'd1, -32'sd3, 4'b0000, 1'b1, 32'd4, 4'b0000);
        step();
        drive("vn6mn2",  1'b0, -32'sd6, -32'sd2, 4'b0000, 1'b1, -32'sd4, 4'b1000);
        step();
        drive("vffm9",   1'b0, 32'hFFFF_FFFF, 32'd9, 4'b0000, 1'b1, -32'sd10, 4'b1010);
        step();
        drive("v10m10",  1'b0, 32'd10, 32'd10, 4'b0000, 1'b1, 32'd0, 4'b0110);
        step();
        drive("v4mn4",   1'b0, 32'd4, -32'sd4, 4'b0000, 1'b1, 32'd8, 4'b0000);
        step();
        drive("ovf_neg", 1'b0, 32'h8000_0000, 32'd1, 4'b0000, 1'b1, OVF_NEG_RES, 4'b0011);
        step();
        drive("ovf_pos", 1'b0, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 4'b0000, 1'b1, OVF_POS_RES, 4'b1001);
        step();
        drive("pass",    1'b0, 32'd10, 32'd10, 4'b0101, 1'b0, 32'd0, 4'b0101);
        step();
        drive("pass_s1", 1'b0, 32'd10, 32'd10, 4'b0101, 1'b1, 32'd0, 4'b0110);
        step();

        drive("mid_rst", 1'b1, 32'd100, 32'd1, 4'b0000, 1'b1, 32'd0, 4'b0000);
        step();
        drive("post_rst", 1'b0, 32'd100, 32'd1, 4'b0000, 1'b1, 32'd99, 4'b0010);
        step();

        // Back-to-back random traffic, including overflow-prone operands.
        for (int i = 0; i < 40; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            a = $urandom();
            b = $urandom();
            if (i % 4 == 0) a = {1'b1, 31'(a)} ^ 32'h7FFF_0000;
            if (i % 5 == 0) b = a;
            drive_model($sformatf("rnd%0d", i), a, b, 4'($urandom()), 1'($urandom()));
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
